imem_uart_loader: RTL
=====================

// Module: imem_uart_loader
// PURPOSE
//  Program loader, the writer side of the instruction stream that the pipeline fetches and decodes.
//  Takes bytes from the UART receiver and packs them big-endian into 32-bit instruction words.
//  Writes the words into instruction memory starting at address 0, and holds the core (PC_En path) while loading.
//  Checks each word's opcode/funct against the set the decoder supports; sets a sticky error flag on a miss.
// PARAMETERS
//  ADDR_WIDTH      8        imem word-address width; max program = 2**ADDR_WIDTH words
//  TIMEOUT_CYCLES  100000   max idle cycles between bytes once a load has started
//  HOLD_AT_RESET   1        1: core_hold resets high (core waits for a load); 0: resets low
// PORTS
//  clk           in   1           system clock
//  reset         in   1           synchronous, active-high reset
//  load_req      in   1           1-cycle pulse: arm loader; ignored unless state IDLE/DONE/ERROR
//  rx_data       in   8           received byte
//  rx_valid      in   1           1-cycle strobe; rx_data is valid in that cycle
//  imem_we       out  1           instruction-memory write enable, 1 cycle per word
//  imem_addr     out  ADDR_WIDTH  word address of the write
//  imem_wdata    out  32          instruction word
//  core_hold     out  1           1: drive PC_En low and keep core in reset
//  busy          out  1           high in HDR_HI, HDR_LO, WORD
//  done          out  1           high in DONE
//  err_illegal   out  1           sticky: at least one unsupported instruction was written
//  err_fatal     out  1           high in ERROR (timeout or oversize)
//  word_count    out  ADDR_WIDTH+1  number of words written in the current load
// BEHAVIOUR
//  Reset values: all outputs 0, except core_hold = HOLD_AT_RESET. State = IDLE.
//  Reset during a load aborts it. Words already written stay in imem.
//  FSM states and transitions:
//   IDLE/DONE/ERROR --load_req--> HDR_HI. On entry: core_hold=1, err_illegal=0, word_count=0, byte index=0.
//   HDR_HI --rx_valid--> HDR_LO. The byte is N[15:8].
//   HDR_LO --rx_valid--> the byte is N[7:0]. Then:
//     N==0 -> DONE.
//     N > 2**ADDR_WIDTH -> ERROR.
//     otherwise -> WORD.
//   WORD: each rx_valid shifts the byte in (first byte = instr[31:24]) and increments the 2-bit byte index.
//     On the 4th byte, the word is latched into the write stage.
//     In the following cycle: imem_we=1, imem_addr=word_count[ADDR_WIDTH-1:0], imem_wdata=word, word_count+1.
//     When the written word is the N-th, state -> DONE in that same cycle.
//   The write stage is separate from the shifter. A byte arriving during the imem_we cycle is accepted (no drop).
//   DONE: core_hold=0, done=1.
//   ERROR: core_hold stays 1, err_fatal=1. Only load_req or reset leaves ERROR.
//  Timeout:
//   The counter clears on every rx_valid and on entry to HDR_HI.
//   In HDR_HI, HDR_LO and WORD, reaching TIMEOUT_CYCLES-1 without rx_valid -> ERROR.
//   A partially packed word is discarded.
//  rx_valid in IDLE/DONE/ERROR is ignored. load_req while busy is ignored.
//  Legality check (on the latched word, same cycle as imem_we):
//   op == 0: legal if funct is one of 00,08,12,18,20,25,2A (hex).
//   op != 0: legal if op is one of 02,03,04,05,06,07,08,0A,0C,0D,0F,23,2B.
//   An illegal word is still written, and err_illegal is set to 1 (sticky until next load_req).
//  Simultaneous load_req and rx_valid in IDLE: load_req wins; the byte is dropped.
// STRUCTURE
//  Shared package (mips_defs_pkg): opcode/funct localparams (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, ... FN_SLL, FN_JR,
//   FN_MFLO, FN_MULT, FN_ADD, FN_OR, FN_SLT), loader state encoding.
//   The same constants are to be used by the decoder.
//  Sub-module: instr_legal_check, a combinational function of a 32-bit word that outputs legal.
//  Top level holds the FSM, byte shifter, timeout counter and write stage.
// TESTING
//  1. Load, N=2, bytes 00 02 | 20 08 00 05 | 00 85 20 20.
//     Expect imem writes (0, 0x20080005), (1, 0x00852020); done=1; core_hold=0; word_count=2; err_illegal=0.
//  2. Header 00 00.
//     Expect DONE one cycle after the 2nd byte, no imem_we, core_hold=0.
//  3. Word FC000000 (op 0x3F) inside N=1.
//     Expect it written at address 0, err_illegal=1, done=1.
//  4. N=1, send 3 bytes, then idle TIMEOUT_CYCLES (set to 16).
//     Expect ERROR at cycle 16, err_fatal=1, no imem_we, core_hold=1.
//  5. Header 01 01 with ADDR_WIDTH=8 (N=257).
//     Expect ERROR immediately after HDR_LO.
//  6. Back-to-back rx_valid every cycle for N=3; reset asserted after word 1; then a second load.
//     Expect no dropped bytes, abort to IDLE, and on the second load addressing restarts at 0.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS opcode/funct constants (also used by the decoder) and the program-loader state encoding.
package mips_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_HDR_HI = 3'd1,
    LD_HDR_LO = 3'd2,
    LD_WORD   = 3'd3,
    LD_DONE   = 3'd4,
    LD_ERROR  = 3'd5
  } loader_state_e;

  function automatic logic [5:0] instr_op(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [5:0] instr_funct(input logic [31:0] instr);
    return instr[5:0];
  endfunction

endpackage

// File: rtl/instr_legal_check.sv
// Combinational check: is this 32-bit word an instruction the decoder supports?
module instr_legal_check
  import mips_defs_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        legal_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_fields;

  assign op            = instr_op(instr_i);
  assign funct         = instr_funct(instr_i);
  assign unused_fields = ^instr_i[25:6];

  always_comb begin
    legal_o = 1'b0;
    if (op == OP_RTYPE) begin
      case (funct)
        FN_SLL, FN_JR, FN_MFLO, FN_MULT, FN_ADD, FN_OR, FN_SLT: legal_o = 1'b1;
        default:                                                legal_o = 1'b0;
      endcase
    end else begin
      case (op)
        OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_ADDI,
        OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW:          legal_o = 1'b1;
        default:                                                legal_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// UART program loader: 16-bit word-count header, then big-endian 32-bit words written to imem from address 0.
// Handshake: rx_valid is a 1-cycle strobe with no backpressure; imem_we is a 1-cycle write with no ready.
module imem_uart_loader
  import mips_defs_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter bit HOLD_AT_RESET  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_req,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err_illegal,
  output logic                  err_fatal,
  output logic [ADDR_WIDTH:0]   word_count,
  output loader_state_e         state_dbg
);

  localparam int                 TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]      TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]      TO_ONE    = TW'(1);
  localparam logic [ADDR_WIDTH:0] WCNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam int unsigned        MAX_WORDS = 32'd1 << ADDR_WIDTH;

  loader_state_e         state_q, state_d;
  logic [15:0]           n_q, n_d;
  logic [23:0]           shift_q, shift_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic                  wr_pend_q, wr_pend_d;
  logic [31:0]           wr_word_q, wr_word_d;
  logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;
  logic                  err_ill_q, err_ill_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  logic                  wr_legal;
  logic                  in_load;
  logic                  last_word;
  logic [15:0]           n_full;

  instr_legal_check u_legal (
    .instr_i (wr_word_q),
    .legal_o (wr_legal)
  );

  assign in_load   = (state_q == LD_HDR_HI) || (state_q == LD_HDR_LO) || (state_q == LD_WORD);
  assign n_full    = {n_q[15:8], rx_data};
  assign last_word = (32'(wcnt_q) + 32'd1) == 32'(n_q);

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    wr_pend_d  = 1'b0;
    wr_word_d  = wr_word_q;
    wcnt_d     = wcnt_q;
    err_ill_d  = err_ill_q;
    tmo_d      = tmo_q;

    // Write stage runs alongside the shifter so a byte in the write cycle is not lost.
    if (wr_pend_q) begin
      wcnt_d = wcnt_q + WCNT_ONE;
      if (!wr_legal) err_ill_d = 1'b1;
    end

    case (state_q)
      LD_IDLE, LD_DONE, LD_ERROR: begin
        if (load_req) begin
          state_d    = LD_HDR_HI;
          err_ill_d  = 1'b0;
          wcnt_d     = '0;
          byte_idx_d = '0;
          tmo_d      = '0;
        end
      end
      LD_HDR_HI: begin
        if (rx_valid) begin
          n_d[15:8] = rx_data;
          tmo_d     = '0;
          state_d   = LD_HDR_LO;
        end
      end
      LD_HDR_LO: begin
        if (rx_valid) begin
          n_d   = n_full;
          tmo_d = '0;
          if (n_full == 16'd0)                   state_d = LD_DONE;
          else if (32'(n_full) > MAX_WORDS)      state_d = LD_ERROR;
          else                                   state_d = LD_WORD;
        end
      end
      LD_WORD: begin
        if (rx_valid) begin
          shift_d    = {shift_q[15:0], rx_data};
          byte_idx_d = byte_idx_q + 2'd1;
          tmo_d      = '0;
          if (byte_idx_q == 2'd3) begin
            wr_pend_d = 1'b1;
            wr_word_d = {shift_q, rx_data};
          end
        end
      end
      default: state_d = LD_IDLE;
    endcase

    // Idle-gap watchdog; a partially packed word is simply abandoned.
    if (in_load && !rx_valid) begin
      if (tmo_q == TO_LAST) state_d = LD_ERROR;
      else                  tmo_d   = tmo_q + TO_ONE;
    end

    if ((state_q == LD_WORD) && wr_pend_q && last_word) state_d = LD_DONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LD_IDLE;
      n_q        <= '0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      wr_pend_q  <= 1'b0;
      wr_word_q  <= '0;
      wcnt_q     <= '0;
      err_ill_q  <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      wr_pend_q  <= wr_pend_d;
      wr_word_q  <= wr_word_d;
      wcnt_q     <= wcnt_d;
      err_ill_q  <= err_ill_d;
      tmo_q      <= tmo_d;
    end
  end

  assign imem_we     = wr_pend_q;
  assign imem_addr   = wcnt_q[ADDR_WIDTH-1:0];
  assign imem_wdata  = wr_word_q;
  assign busy        = in_load;
  assign done        = (state_q == LD_DONE);
  assign err_fatal   = (state_q == LD_ERROR);
  assign err_illegal = err_ill_q;
  assign word_count  = wcnt_q;
  assign state_dbg   = state_q;
  // IDLE is only reachable through reset, so its hold level is the reset choice.
  assign core_hold   = (state_q == LD_IDLE) ? HOLD_AT_RESET : (state_q != LD_DONE);

endmodule
